mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit, the next-generation HI/LO unit for the pipelined core's EX stage. It executes signed and unsigned mult, div, madd and msub using a radix-2 shift-add/restoring engine, one bit per cycle. It exposes a start/busy/done handshake, supports exception flush, and flags divide-by-zero. HI/LO are architectural and change only on completion, reset, or mt writes.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_iter_if.sv | 26 ++
 rtl/mdu_shift_core.sv | 80 ++++++++
 rtl/mdu_iter.sv | 162 ++++++++++++++++
 tb/tb_mdu_iter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, HI/LO move codes and FSM state encodings for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [3:0] MULTU = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] DIVU  = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] MADDU = 4'd4;
    localparam logic [3:0] MADD  = 4'd5;
    localparam logic [3:0] MSUBU = 4'd6;
    localparam logic [3:0] MSUB  = 4'd7;

    localparam logic [1:0] MT_LO = 2'b01;
    localparam logic [1:0] MT_HI = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_FIX  = 2'd2;

endpackage

// File: rtl/mdu_iter_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mdu_iter_if #(parameter int WIDTH = 32);

    logic             start;
    logic [3:0]       op;
    logic [1:0]       mthilo;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             clr;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, mthilo, src_a, src_b, clr,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, mthilo, src_a, src_b, clr,
        output hi, lo, busy, done, div_zero
    );

endinterface

// File: rtl/mdu_shift_core.sv
// One-bit-per-cycle shift-add multiply / restoring divide datapath on operand magnitudes.
// MDU_EARLY_OUT_EN: multiplies report last as soon as the remaining multiplier bits are zero.
module mdu_shift_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               flush_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               last_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic [WIDTH:0]     diff;

    // Divide keeps {remainder, quotient} in acc; the trial subtract sees acc shifted left by one.
    assign diff  = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mc_q[WIDTH-1:0]};
    assign acc_o = acc_q;

`ifdef MDU_EARLY_OUT_EN
    assign last_o = (cnt_q == CNT_W'(1)) || (!div_q && (mq_q[WIDTH-1:1] == '0));
`else
    assign last_o = (cnt_q == CNT_W'(1));
`endif

    always_comb begin
        acc_d = acc_q;
        mc_d  = mc_q;
        mq_d  = mq_q;
        cnt_d = cnt_q;
        div_d = div_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(WIDTH);
            div_d = div_i;
            mq_d  = div_i ? '0 : b_i;
            acc_d = div_i ? {{WIDTH{1'b0}}, a_i} : '0;
            mc_d  = div_i ? {{WIDTH{1'b0}}, b_i} : {{WIDTH{1'b0}}, a_i};
        end else if (step_i) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (div_q) begin
                if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end else begin
                if (mq_q[0]) acc_d = acc_q + mc_q;
                mc_d = mc_q << 1;
                mq_d = mq_q >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
            mc_q  <= '0;
            mq_q  <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            mc_q  <= mc_d;
            mq_q  <= mq_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative HI/LO multiply/divide unit: start->done in WIDTH+1 cycles, caller stalls on busy.
// MDU_EARLY_OUT_EN shortens multiply latency to (msb index of |b|)+2.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    reset,
    mdu_iter_if.slave bus
);

    import mdu_pkg::*;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dzf_q, dzf_d;
    logic [2*WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               core_load, core_step, core_flush, core_last;
    logic [2*WIDTH-1:0] core_acc, sprod;
    logic               op_ok, op_div, sa, sb;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;

    always_comb begin
        op_ok = 1'b0;
        case (bus.op)
            MULTU, MULT, DIVU, DIV, MADDU, MADD, MSUBU, MSUB: op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end

    assign op_div = (bus.op[2:1] == 2'b01);
    assign sa     = bus.op[0] & bus.src_a[WIDTH-1];
    assign sb     = bus.op[0] & bus.src_b[WIDTH-1];
    assign a_mag  = sa ? -bus.src_a : bus.src_a;
    assign b_mag  = sb ? -bus.src_b : bus.src_b;

    // Quotient sign shares neg_q with the product sign; remainder follows the dividend.
    assign sprod = neg_q ? -core_acc : core_acc;
    assign quo   = neg_q ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
    assign rem   = rneg_q ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];

    mdu_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .load_i  (core_load),
        .step_i  (core_step),
        .flush_i (core_flush),
        .div_i   (op_div),
        .a_i     (a_mag),
        .b_i     (b_mag),
        .acc_o   (core_acc),
        .last_o  (core_last)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        dzf_d      = dzf_q;
        snap_d     = snap_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dz_d       = 1'b0;
        core_load  = 1'b0;
        core_step  = 1'b0;
        core_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.clr) begin
                    if (bus.start) begin
                        if (op_ok) begin
                            core_load = 1'b1;
                            op_d      = bus.op[2:0];
                            neg_d     = sa ^ sb;
                            rneg_d    = sa;
                            dzf_d     = op_div && (bus.src_b == '0);
                            snap_d    = op_div ? {{WIDTH{1'b0}}, bus.src_a} : {hi_q, lo_q};
                            state_d   = ST_CALC;
                        end
                    end else if (bus.mthilo == MT_LO) begin
                        lo_d = bus.src_a;
                    end else if (bus.mthilo == MT_HI) begin
                        hi_d = bus.src_a;
                    end
                end
            end
            ST_CALC: begin
                if (bus.clr) begin
                    core_flush = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    core_step = 1'b1;
                    if (core_last) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (bus.clr) begin
                    core_flush = 1'b1;
                end else begin
                    done_d = 1'b1;
                    dz_d   = dzf_q;
                    case (op_q[2:1])
                        2'b00: {hi_d, lo_d} = sprod;
                        2'b10: {hi_d, lo_d} = snap_q + sprod;
                        2'b11: {hi_d, lo_d} = snap_q - sprod;
                        default: begin
                            if (dzf_q) begin
                                hi_d = snap_q[WIDTH-1:0];
                                lo_d = '1;
                            end else begin
                                hi_d = rem;
                                lo_d = quo;
                            end
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dzf_q   <= 1'b0;
            snap_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dzf_q   <= dzf_d;
            snap_q  <= snap_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: a 64-bit arithmetic model predicts HI/LO/div_zero and latency per op.
module tb_mdu_iter;

    import mdu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic         dz;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    typedef struct packed {
        exp_t       r;
        logic       busy0;
        logic       busy_d;
        logic [7:0] lat;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(W)) bus ();
    mdu_iter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    exp_t         sb_q[$];
    logic [W-1:0] m_hi, m_lo;
    int           n_vec = 0;
    int           n_err = 0;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sb;
        logic [63:0] acc, up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        acc = {m_hi, m_lo};
        up  = {32'b0, a} * {32'b0, b};
        e   = '{dz: 1'b0, hi: m_hi, lo: m_lo};
        case (op)
            MULTU: {e.hi, e.lo} = up;
            MULT:  {e.hi, e.lo} = 64'(sa * sb);
            MADDU: {e.hi, e.lo} = acc + up;
            MADD:  {e.hi, e.lo} = acc + 64'(sa * sb);
            MSUBU: {e.hi, e.lo} = acc - up;
            MSUB:  {e.hi, e.lo} = acc - 64'(sa * sb);
            default: begin
                if (b == '0) begin
                    e.dz = 1'b1;
                    e.lo = '1;
                    e.hi = a;
                end else if (op == DIVU) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else begin
                    e.lo = W'(sa / sb);
                    e.hi = W'(sa % sb);
                end
            end
        endcase
        return e;
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [W-1:0] b);
        int l;
        l = W + 1;
`ifdef MDU_EARLY_OUT_EN
        if (op[2:1] != 2'b01) begin
            logic [W-1:0] m;
            m = (op[0] && b[W-1]) ? -b : b;
            l = 2;
            for (int i = 0; i < W; i++) if (m[i]) l = i + 2;
        end
`endif
        return l;
    endfunction

    task automatic drive_idle();
        bus.start = 1'b0; bus.op = 4'd0; bus.mthilo = 2'b00;
        bus.src_a = '0; bus.src_b = '0; bus.clr = 1'b0;
    endtask

    // Issues one op, optionally poking a second start mid-flight, and records what the DUT did.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke, output obs_t o);
        exp_t e;
        int   k;
        e = model(op, a, b);
        sb_q.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.src_a = $urandom; bus.src_b = $urandom;
        o.busy0 = bus.busy;
        k = 0;
        while (!bus.done && k < 100) begin
            @(negedge clk);
            k++;
            if (poke && k == 3) begin
                bus.start = 1'b1; bus.op = MULTU;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        o.lat    = (k < 100) ? 8'(k) : 8'hFF;
        o.busy_d = bus.busy;
        o.r      = {bus.div_zero, bus.hi, bus.lo};
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero} !== '0) begin
            n_err++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b, want all zero",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.div_zero);
        end
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_mul();
        logic [3:0]   ops[6] = '{MULTU, MULT, MADD, MSUBU, MSUB, MADDU};
        logic [W-1:0] as[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd2, 32'd3, 32'h8000_0000, 32'd7};
        logic [W-1:0] bs[6]  = '{32'hFFFF_FFFF, 32'd7, 32'd5, 32'd4, 32'h8000_0000, 32'd0};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], 1'b0, o);
            e = sb_q.pop_front();
            n_vec++;
            if (o.r !== e) begin
                n_err++;
                $display("FAIL mul[%0d] result: hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
                         i, o.r.hi, o.r.lo, o.r.dz, e.hi, e.lo, e.dz);
            end
            n_vec++;
            if (int'(o.lat) != exp_lat(ops[i], bs[i])) begin
                n_err++;
                $display("FAIL mul[%0d] latency: %0d, want %0d", i, o.lat, exp_lat(ops[i], bs[i]));
            end
            n_vec++;
            if (o.busy0 !== 1'b1 || o.busy_d !== 1'b0) begin
                n_err++;
                $display("FAIL mul[%0d] busy: after start %b at done %b, want 1 and 0", i, o.busy0, o.busy_d);
            end
        end
    endtask

    task automatic test_div();
        logic [3:0]   ops[6] = '{DIV, DIV, DIVU, DIV, DIVU, DIV};
        logic [W-1:0] as[6]  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd123, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [W-1:0] bs[6]  = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 32'd3, 32'd0};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], 1'b0, o);
            e = sb_q.pop_front();
            n_vec++;
            if (o.r !== e) begin
                n_err++;
                $display("FAIL div[%0d] result: hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
                         i, o.r.hi, o.r.lo, o.r.dz, e.hi, e.lo, e.dz);
            end
            n_vec++;
            if (int'(o.lat) != W + 1) begin
                n_err++;
                $display("FAIL div[%0d] latency: %0d, want %0d", i, o.lat, W + 1);
            end
        end
    endtask

    task automatic test_clr_mthilo();
        int dones;
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIVU; bus.src_a = 32'd1000; bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
            n_err++;
            $display("FAIL clr abort: busy=%b done=%b hi=%h lo=%h, want 0 0 %h %h",
                     bus.busy, bus.done, bus.hi, bus.lo, m_hi, m_lo);
        end
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_vec++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL clr no-done: %0d done pulses, want 0", dones);
        end
        bus.mthilo = MT_HI; bus.src_a = 32'h1234;
        @(negedge clk);
        bus.mthilo = 2'b00;
        m_hi = 32'h1234;
        n_vec++;
        if (bus.hi !== m_hi || bus.lo !== m_lo || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL mthi: hi=%h lo=%h done=%b, want %h %h 0", bus.hi, bus.lo, bus.done, m_hi, m_lo);
        end
        bus.mthilo = MT_LO; bus.src_a = 32'hCAFE_0001;
        @(negedge clk);
        bus.mthilo = 2'b00;
        m_lo = 32'hCAFE_0001;
        n_vec++;
        if (bus.lo !== m_lo || bus.hi !== m_hi) begin
            n_err++;
            $display("FAIL mtlo: hi=%h lo=%h, want %h %h", bus.hi, bus.lo, m_hi, m_lo);
        end
        bus.clr = 1'b1; bus.mthilo = MT_LO; bus.src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.clr = 1'b0; bus.mthilo = 2'b00;
        n_vec++;
        if (bus.lo !== m_lo) begin
            n_err++;
            $display("FAIL clr blocks mt: lo=%h, want %h", bus.lo, m_lo);
        end
        bus.start = 1'b1; bus.op = 4'hA; bus.mthilo = MT_LO; bus.src_a = 32'h5555_5555;
        @(negedge clk);
        bus.start = 1'b0; bus.mthilo = 2'b00;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.lo !== m_lo) begin
            n_err++;
            $display("FAIL bad-op start: busy=%b lo=%h, want 0 %h", bus.busy, bus.lo, m_lo);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1; bus.op = MULT; bus.src_a = 32'h0001_2345; bus.src_b = 32'hFFFF_0003;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        n_vec++;
        if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset mid-op: hi=%h lo=%h busy=%b done=%b, want 0 0 0 0",
                     bus.hi, bus.lo, bus.busy, bus.done);
        end
    endtask

    task automatic test_back_to_back();
        obs_t         o;
        exp_t         e;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 14; i++) begin
            op = 4'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) b = -b;
            do_op(op, a, b, (i % 3) == 1, o);
            e = sb_q.pop_front();
            n_vec++;
            if (o.r !== e) begin
                n_err++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h: hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=%b",
                         i, op, a, b, o.r.hi, o.r.lo, o.r.dz, e.hi, e.lo, e.dz);
            end
            n_vec++;
            if (int'(o.lat) != exp_lat(op, b)) begin
                n_err++;
                $display("FAIL b2b[%0d] latency op=%0d b=%h: %0d, want %0d", i, op, b, o.lat, exp_lat(op, b));
            end
            @(negedge clk);
            n_vec++;
            if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
                n_err++;
                $display("FAIL b2b[%0d] pulse width: done=%b dz=%b one cycle later, want 0 0",
                         i, bus.done, bus.div_zero);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_clr_mthilo();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
